// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq_if
// Description : Request/result bundle between a binary source and the
//               sequential binary-to-BCD converter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
  parameter int IN_WIDTH = 16
);
  logic                start;
  logic [IN_WIDTH-1:0] bin;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [3:0]          num1;
  logic [3:0]          num2;
  logic [3:0]          num3;
  logic [3:0]          num4;

  // Requester side: issues start/bin, observes the converted digits
  modport master (
    output start, bin,
    input  busy, done, ovf, num1, num2, num3, num4
  );

  // Converter side
  modport slave (
    input  start, bin,
    output busy, done, ovf, num1, num2, num3, num4
  );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential shift-and-add-3 (double dabble) binary-to-BCD
//               converter, one input bit per clock. Results above 9999
//               saturate to 9999 and raise ovf. Digit outputs are registered
//               and only change when a conversion completes.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
  parameter int IN_WIDTH = 16   // legal range 4..16; must match the interface
) (
  input  wire             clk,
  input  wire             rst_n,
  bin2bcd_seq_if.slave    bus
);

  localparam int ACC_W   = 20;  // five BCD digits, enough for 2^16-1
  localparam int DIGITS  = 5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state;
  logic [IN_WIDTH-1:0]   r_shift;
  logic [ACC_W-1:0]      r_acc;
  logic [4:0]            r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_ovf;
  logic [3:0]            r_num1;
  logic [3:0]            r_num2;
  logic [3:0]            r_num3;
  logic [3:0]            r_num4;

  logic [ACC_W-1:0]          w_adj;
  logic [ACC_W+IN_WIDTH-1:0] w_shifted;

  // Add 3 to every accumulator digit that is 5 or more, ahead of the shift
  for (genvar d = 0; d < DIGITS; d++) begin : g_digit_adj
    assign w_adj[4*d +: 4] = (r_acc[4*d +: 4] >= 4'd5) ? (r_acc[4*d +: 4] + 4'd3)
                                                        : r_acc[4*d +: 4];
  end

  assign w_shifted = {w_adj, r_shift} << 1;

  // Conversion FSM: capture, shift IN_WIDTH times, then publish the digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_num1  <= 4'd0;
      r_num2  <= 4'd0;
      r_num3  <= 4'd0;
      r_num4  <= 4'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_shift <= bus.bin;
            r_acc   <= '0;
            r_cnt   <= 5'(IN_WIDTH);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          {r_acc, r_shift} <= w_shifted;
          r_cnt            <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) begin
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          // A non-zero ten-thousands digit means the value exceeds 9999
          if (r_acc[19:16] != 4'd0) begin
            r_num1 <= 4'd9;
            r_num2 <= 4'd9;
            r_num3 <= 4'd9;
            r_num4 <= 4'd9;
            r_ovf  <= 1'b1;
          end else begin
            r_num1 <= r_acc[3:0];
            r_num2 <= r_acc[7:4];
            r_num3 <= r_acc[11:8];
            r_num4 <= r_acc[15:12];
            r_ovf  <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.ovf  = r_ovf;
  assign bus.num1 = r_num1;
  assign bus.num2 = r_num2;
  assign bus.num3 = r_num3;
  assign bus.num4 = r_num4;

endmodule
`default_nettype wire
